// File: rtl/cpu.sv
// cpu: five-stage pipelined MIPS-subset core (IF ID EX MEM WB)
// with internal instruction ROM, register file and data memory.
module dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem_array [0:63];

  assign rdata = mem_array[addr];

  always_ff @(posedge clk)
    if (we) mem_array[addr] <= wdata;
endmodule

module cpu (
  input logic clka,
  input logic rst
);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic       ld;
  } ctl_t;

  logic [31:0] ram         [0:63];
  logic [31:0] register    [0:31];
  logic [31:0] instruction [0:4];

  logic [31:0] pc, pc0, pc1;
  logic [31:0] a1, b1, b2, alu2, alu3, ld3;

  function automatic ctl_t decode(input logic [31:0] ir);
    ctl_t c;
    c = '0;
    unique case (ir[31:26])
      OP_R: begin
        c.wr  = ir[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
        c.dst = ir[15:11];
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        c.wr  = 1'b1;
        c.dst = ir[20:16];
      end
      OP_LW: begin
        c.wr  = 1'b1;
        c.ld  = 1'b1;
        c.dst = ir[20:16];
      end
      default: ;
    endcase
    if (c.dst == 5'd0) c.wr = 1'b0;
    return c;
  endfunction

  // WB stage
  ctl_t        wb;
  logic [31:0] wb_val;

  assign wb     = decode(instruction[3]);
  assign wb_val = wb.ld ? ld3 : alu3;

  always_ff @(posedge clka)
    if (wb.wr) register[wb.dst] <= wb_val;

  // ID stage, with write-through bypass from WB
  logic [4:0]  rs_id, rt_id;
  logic [31:0] rs_rd, rt_rd;

  assign rs_id = instruction[0][25:21];
  assign rt_id = instruction[0][20:16];

  always_comb begin
    rs_rd = register[rs_id];
    rt_rd = register[rt_id];
    if (wb.wr && wb.dst == rs_id) rs_rd = wb_val;
    if (wb.wr && wb.dst == rt_id) rt_rd = wb_val;
    if (rs_id == 5'd0) rs_rd = '0;
    if (rt_id == 5'd0) rt_rd = '0;
  end

  // EX stage
  logic [5:0]  op, fn;
  logic [31:0] simm, zimm, link, alu, target;
  logic        take;

  assign op   = instruction[1][31:26];
  assign fn   = instruction[1][5:0];
  assign simm = {{16{instruction[1][15]}}, instruction[1][15:0]};
  assign zimm = {16'h0, instruction[1][15:0]};
  assign link = pc1 + 32'd4;

  always_comb begin
    alu = '0;
    unique case (op)
      OP_R: begin
        unique case (fn)
          F_ADD:   alu = a1 + b1;
          F_SUB:   alu = a1 - b1;
          F_AND:   alu = a1 & b1;
          F_OR:    alu = a1 | b1;
          F_NOR:   alu = ~(a1 | b1);
          F_SLT:   alu = {31'd0, $signed(a1) < $signed(b1)};
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu = a1 + simm;
      OP_SLTI: alu = {31'd0, $signed(a1) < $signed(simm)};
      OP_ANDI: alu = a1 & zimm;
      OP_ORI:  alu = a1 | zimm;
      default: ;
    endcase
  end

  always_comb begin
    take   = 1'b0;
    target = link + (simm << 2);
    unique case (1'b1)
      op == OP_J: begin
        take   = 1'b1;
        target = {link[31:28], instruction[1][25:0], 2'b00};
      end
      op == OP_BEQ: take = (a1 == b1);
      op == OP_BNE: take = (a1 != b1);
      default: ;
    endcase
  end

  // MEM stage
  logic        st2;
  logic [31:0] rdata;

  assign st2 = instruction[2][31:26] == OP_SW;

  dmem memory (
    .clk   (clka),
    .we    (st2),
    .addr  (alu2[7:2]),
    .wdata (b2),
    .rdata (rdata)
  );

  // taken branch squashes the two younger instructions
  always_ff @(posedge clka or posedge rst)
    if (rst) begin
      pc   <= '0;
      pc0  <= '0;
      pc1  <= '0;
      a1   <= '0;
      b1   <= '0;
      b2   <= '0;
      alu2 <= '0;
      alu3 <= '0;
      ld3  <= '0;
      for (int i = 0; i < 5; i++) instruction[i] <= '0;
    end else begin
      instruction[0] <= take ? '0 : ram[pc[7:2]];
      instruction[1] <= take ? '0 : instruction[0];
      instruction[2] <= instruction[1];
      instruction[3] <= instruction[2];
      instruction[4] <= instruction[3];
      pc   <= take ? target : pc + 32'd4;
      pc0  <= pc;
      pc1  <= pc0;
      a1   <= rs_rd;
      b1   <= rt_rd;
      alu2 <= alu;
      b2   <= b1;
      alu3 <= alu2;
      ld3  <= rdata;
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed pipeline checks plus random hazard-free programs
// compared against an instruction-level reference model.
module tb_cpu;
  logic clka = 1'b0;
  logic rst  = 1'b1;

  cpu dut (
    .clka (clka),
    .rst  (rst)
  );

  always #5 clka = ~clka;

  int compared   = 0;
  int mismatched = 0;
  int edge_n     = 0;

  logic [31:0] prog [64];
  logic [31:0] mreg [32];
  logic [31:0] mmem [64];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int upto);
    while (edge_n < upto) begin
      @(posedge clka);
      edge_n++;
    end
    #1;
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rd,
                                        input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt,
                                        input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int w);
    return {6'h02, 26'(w)};
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mreg[r] = v;
  endtask

  // instruction-level model: one instruction at a time, no delay slot
  task automatic model_run();
    logic [31:0] ir, a, b, s, z, ea, pcb, tgt;
    int p, np;
    p = 0;
    for (int n = 0; n < 200; n++) begin
      ir  = prog[p];
      a   = mreg[ir[25:21]];
      b   = mreg[ir[20:16]];
      s   = {{16{ir[15]}}, ir[15:0]};
      z   = {16'h0, ir[15:0]};
      ea  = a + s;
      pcb = 32'(p * 4);
      np  = (p + 1) % 64;
      case (ir[31:26])
        6'h00: case (ir[5:0])
          6'h20: wr(ir[15:11], a + b);
          6'h22: wr(ir[15:11], a - b);
          6'h24: wr(ir[15:11], a & b);
          6'h25: wr(ir[15:11], a | b);
          6'h27: wr(ir[15:11], ~(a | b));
          6'h2A: wr(ir[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
        6'h08: wr(ir[20:16], a + s);
        6'h0A: wr(ir[20:16], ($signed(a) < $signed(s)) ? 32'd1 : 32'd0);
        6'h0C: wr(ir[20:16], a & z);
        6'h0D: wr(ir[20:16], a | z);
        6'h23: wr(ir[20:16], mmem[ea[7:2]]);
        6'h2B: mmem[ea[7:2]] = b;
        6'h04, 6'h05: if ((a == b) == (ir[31:26] == 6'h04)) begin
          tgt = pcb + 32'd4 + (s << 2);
          np  = int'(tgt[7:2]);
        end
        6'h02: begin
          tgt = pcb + 32'd4;
          tgt = {tgt[31:28], ir[25:0], 2'b00};
          np  = int'(tgt[7:2]);
        end
        default: ;
      endcase
      if (np == p) break;
      p = np;
    end
  endtask

  function automatic logic [31:0] rand_instr(input int s, input int last);
    int k, rs, rt, rd, t, fn;
    k  = $urandom_range(0, 12);
    rs = $urandom_range(0, 31);
    rt = $urandom_range(0, 31);
    rd = $urandom_range(0, 31);
    t  = $urandom_range(s + 1, last);
    case ($urandom_range(0, 5))
      0: fn = 'h20;
      1: fn = 'h22;
      2: fn = 'h24;
      3: fn = 'h25;
      4: fn = 'h27;
      default: fn = 'h2A;
    endcase
    if ($urandom_range(0, 1) == 1) rt = rs;
    case (k)
      0, 1: return enc_r(fn, rd, rs, rt);
      2:  return enc_i('h08, rt, rs, int'($urandom_range(0, 65535)));
      3:  return enc_i('h0A, rt, rs, int'($urandom_range(0, 65535)));
      4:  return enc_i('h0C, rt, rs, int'($urandom_range(0, 65535)));
      5:  return enc_i('h0D, rt, rs, int'($urandom_range(0, 65535)));
      6:  return enc_i('h23, rt, rs, int'($urandom_range(0, 65535)));
      7:  return enc_i('h2B, rt, rs, int'($urandom_range(0, 65535)));
      8:  return enc_i('h04, rt, rs, 3 * (t - s) - 1);
      9:  return enc_i('h05, rt, rs, 3 * (t - s) - 1);
      10: return enc_j(3 * t);
      11: return {6'h00, 20'($urandom), 6'h00};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] d [64];
    int nslot;

    // directed program; every producer is followed by exactly 2 NOPs
    for (int i = 0; i < 64; i++) d[i] = 32'h0;
    d[0]  = enc_r('h20, 3, 1, 2);
    d[3]  = enc_r('h22, 4, 1, 2);
    d[6]  = enc_r('h2A, 5, 2, 1);
    d[9]  = enc_i('h23, 6, 0, 4);
    d[12] = enc_i('h2B, 6, 0, 8);
    d[15] = enc_i('h08, 0, 0, 5);
    d[18] = enc_i('h08, 7, 7, 1);
    d[21] = enc_i('h04, 0, 0, 2);
    d[22] = enc_i('h08, 8, 0, 1);
    d[23] = enc_i('h08, 9, 0, 1);
    d[24] = enc_i('h08, 10, 0, 3);
    d[27] = enc_i('h08, 11, 10, 4);
    d[30] = enc_j(30);

    rst = 1'b1;
    repeat (3) @(posedge clka);
    for (int i = 0; i < 64; i++) begin
      dut.ram[i] = d[i];
      dut.memory.mem_array[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.register[i] = 32'h0;
    dut.register[1] = 32'd5;
    dut.register[2] = 32'd7;
    dut.register[5] = 32'h55;
    dut.register[7] = 32'hFFFF_FFFF;
    dut.register[8] = 32'h88;
    dut.register[9] = 32'h99;
    dut.memory.mem_array[1] = 32'd9;
    dut.memory.mem_array[2] = 32'h1234;
    #1;
    check("reset pc", dut.pc, 32'h0);
    for (int k = 0; k < 5; k++)
      check($sformatf("reset instruction[%0d]", k), dut.instruction[k], 32'h0);

    @(negedge clka);
    rst = 1'b0;
    edge_n = 0;
    step(1);
    check("first fetch", dut.instruction[0], d[0]);
    check("pc after first fetch", dut.pc, 32'd4);

    step(13);
    check("lw not yet written", dut.register[6], 32'h0);
    step(14);
    check("lw writeback edge", dut.register[6], 32'd9);
    step(15);
    check("sw not yet stored", dut.memory.mem_array[2], 32'h1234);
    step(16);
    check("sw store edge", dut.memory.mem_array[2], 32'd9);

    step(24);
    check("branch squash instruction[0]", dut.instruction[0], 32'h0);
    check("branch squash instruction[1]", dut.instruction[1], 32'h0);
    check("branch in MEM", dut.instruction[2], d[21]);
    check("branch pc", dut.pc, 32'd96);

    step(45);
    check("add r3", dut.register[3], 32'd12);
    check("sub r4", dut.register[4], 32'hFFFF_FFFE);
    check("slt r5", dut.register[5], 32'h0);
    check("zero reg", dut.register[0], 32'h0);
    check("addi wrap r7", dut.register[7], 32'h0);
    check("squashed r8", dut.register[8], 32'h88);
    check("squashed r9", dut.register[9], 32'h99);
    check("branch target r10", dut.register[10], 32'd3);
    check("bypass r11", dut.register[11], 32'd7);

    // asynchronous reset between edges
    @(posedge clka);
    #3 rst = 1'b1;
    #1;
    check("async reset pc", dut.pc, 32'h0);
    for (int k = 0; k < 5; k++)
      check($sformatf("async reset instruction[%0d]", k),
            dut.instruction[k], 32'h0);

    // random programs: each instruction padded by 2 NOPs, forward branches
    for (int t = 0; t < 30; t++) begin
      nslot = $urandom_range(6, 21);
      for (int i = 0; i < 64; i++) prog[i] = 32'h0;
      for (int s = 0; s < nslot - 1; s++)
        prog[3 * s] = rand_instr(s, nslot - 1);
      prog[3 * (nslot - 1)] = enc_j(3 * (nslot - 1));

      rst = 1'b1;
      @(negedge clka);
      for (int i = 0; i < 64; i++) begin
        mmem[i] = $urandom;
        dut.ram[i] = prog[i];
        dut.memory.mem_array[i] = mmem[i];
      end
      for (int i = 0; i < 32; i++) begin
        mreg[i] = (i == 0) ? 32'h0 : $urandom;
        dut.register[i] = mreg[i];
      end
      model_run();
      @(negedge clka);
      rst = 1'b0;
      repeat (100) @(posedge clka);
      #1;
      for (int i = 0; i < 32; i++)
        check($sformatf("t%0d register[%0d]", t, i),
              dut.register[i], mreg[i]);
      for (int i = 0; i < 64; i++)
        check($sformatf("t%0d mem_array[%0d]", t, i),
              dut.memory.mem_array[i], mmem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
